mem_arbiter: RTL and testbench

- Sole owner of the 8-bit unified RAM port.
- Arbitrates between the icache miss path and the load/store buffer (LSB).
- Serialises each 1/2/4-byte access into byte cycles; assembles read words little-endian, splits write words.
- Sits between icache/LSB and the RAM wrapper; returns one-cycle completion pulses.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : state/size encodings and helpers shared by mem_arbiter
// Rev 1.0
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_LOAD   = 2'd2,
        ST_STORE  = 2'd3
    } state_t;

    localparam logic [1:0]  SZ_B = 2'd0;
    localparam logic [1:0]  SZ_H = 2'd1;
    localparam logic [1:0]  SZ_W = 2'd2;

    localparam logic        TRUE  = 1'b1;
    localparam logic        FALSE = 1'b0;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // Size code 3 is not a legal LSB size; it falls through to a full word.
    function automatic logic [2:0] xfer_len(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : owns the 8-bit RAM port, serialises icache/LSB accesses
//               into byte cycles. Optional macro IO_STALL_EN adds
//               io_buffer_full back-pressure on I/O stores.
// Rev 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              ic_addr_sgn,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [31:0]       ic_val,
    output logic              ic_val_sgn,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
`ifdef IO_STALL_EN
    ,
    input  logic              io_buffer_full
`endif
);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;

    logic [31:0]       ic_val_q, ic_val_d;
    logic              ic_val_sgn_q, ic_val_sgn_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic              ls_done_q, ls_done_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic              mem_wr_q, mem_wr_d;

    logic              w_stall;
    logic              w_stall_acc;
    logic [1:0]        w_rd_idx;
    logic [31:0]       w_buf_ins;
    logic [ADDR_W-1:0] w_rd_addr;

`ifdef IO_STALL_EN
    logic io_q, io_d;

    // Stall the pending byte of an I/O store while the I/O buffer is full.
    assign w_stall_acc = (ls_addr >= IO_BASE) && io_buffer_full;
    assign w_stall     = io_q && io_buffer_full;
`else
    assign w_stall_acc = FALSE;
    assign w_stall     = FALSE;
`endif

    // The byte arriving now belongs to the address issued one edge earlier.
    assign w_rd_idx  = cnt_q[1:0] - 2'd1;
    assign w_rd_addr = ls_req ? ls_addr : ic_addr;

    always_comb begin
        w_buf_ins = buf_q;
        w_buf_ins[{w_rd_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        ic_val_d     = ic_val_q;
        ls_rdata_d   = ls_rdata_q;
        ic_val_sgn_d = FALSE;
        ls_done_d    = FALSE;
        mem_dout_d   = mem_dout_q;
        mem_a_d      = mem_a_q;
        mem_wr_d     = FALSE;
`ifdef IO_STALL_EN
        io_d         = io_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // A done pulse still high means the requester has not yet dropped its request.
                if (!ic_val_sgn_q && !ls_done_q) begin
                    if (ls_req && ls_wr) begin
                        state_d = ST_STORE;
                        len_d   = xfer_len(ls_size);
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
`ifdef IO_STALL_EN
                        io_d    = (ls_addr >= IO_BASE);
`endif
                        if (w_stall_acc) begin
                            cnt_d = 3'd0;
                        end else begin
                            mem_a_d    = ls_addr;
                            mem_dout_d = ls_wdata[7:0];
                            mem_wr_d   = TRUE;
                            cnt_d      = 3'd1;
                        end
                    end else if (!rollback && (ls_req || ic_addr_sgn)) begin
                        state_d = ls_req ? ST_LOAD : ST_IFETCH;
                        len_d   = ls_req ? xfer_len(ls_size) : 3'd4;
                        addr_d  = w_rd_addr;
                        mem_a_d = w_rd_addr;
                        cnt_d   = 3'd1;
                        buf_d   = '0;
                    end
                end
            end
            ST_IFETCH, ST_LOAD: begin
                if (rollback) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    buf_d   = '0;
                end else if (cnt_q < len_q) begin
                    buf_d   = w_buf_ins;
                    mem_a_d = addr_q + ADDR_W'(cnt_q);
                    cnt_d   = cnt_q + 3'd1;
                end else begin
                    buf_d   = w_buf_ins;
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    if (state_q == ST_IFETCH) begin
                        ic_val_d     = w_buf_ins;
                        ic_val_sgn_d = TRUE;
                    end else begin
                        ls_rdata_d = w_buf_ins;
                        ls_done_d  = TRUE;
                    end
                end
            end
            ST_STORE: begin
                // Stores are already committed, so rollback is ignored here.
                if (cnt_q < len_q) begin
                    if (!w_stall) begin
                        mem_a_d    = addr_q + ADDR_W'(cnt_q);
                        mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        mem_wr_d   = TRUE;
                        cnt_d      = cnt_q + 3'd1;
                    end
                end else begin
                    mem_a_d   = '0;
                    state_d   = ST_IDLE;
                    cnt_d     = 3'd0;
                    ls_done_d = TRUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            ic_val_q     <= '0;
            ic_val_sgn_q <= FALSE;
            ls_rdata_q   <= '0;
            ls_done_q    <= FALSE;
            mem_dout_q   <= '0;
            mem_a_q      <= '0;
            mem_wr_q     <= FALSE;
`ifdef IO_STALL_EN
            io_q         <= FALSE;
`endif
        end else if (rdy) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            ic_val_q     <= ic_val_d;
            ic_val_sgn_q <= ic_val_sgn_d;
            ls_rdata_q   <= ls_rdata_d;
            ls_done_q    <= ls_done_d;
            mem_dout_q   <= mem_dout_d;
            mem_a_q      <= mem_a_d;
            mem_wr_q     <= mem_wr_d;
`ifdef IO_STALL_EN
            io_q         <= io_d;
`endif
        end
    end

    assign ic_val     = ic_val_q;
    assign ic_val_sgn = ic_val_sgn_q;
    assign ls_rdata   = ls_rdata_q;
    assign ls_done    = ls_done_q;
    assign mem_dout   = mem_dout_q;
    assign mem_a      = mem_a_q;
    assign mem_wr     = mem_wr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : table vectors, corner sequences and random traffic against
//                  a byte-level memory model for mem_arbiter
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int TO = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic        ic_addr_sgn = 1'b0;
    logic [31:0] ic_addr = '0;
    logic [31:0] ic_val;
    logic        ic_val_sgn;
    logic        ls_req = 1'b0;
    logic        ls_wr = 1'b0;
    logic [1:0]  ls_size = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
`ifdef IO_STALL_EN
    logic        io_buffer_full = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int wr_total  = 0;
    int ic_pulses = 0;

    logic [7:0] dev_ram [logic [31:0]];
    logic [7:0] exp_mem [logic [31:0]];

    mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .rollback    (rollback),
        .ic_addr_sgn (ic_addr_sgn),
        .ic_addr     (ic_addr),
        .ic_val      (ic_val),
        .ic_val_sgn  (ic_val_sgn),
        .ls_req      (ls_req),
        .ls_wr       (ls_wr),
        .ls_size     (ls_size),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_rdata    (ls_rdata),
        .ls_done     (ls_done),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .mem_a       (mem_a),
        .mem_wr      (mem_wr)
`ifdef IO_STALL_EN
        ,
        .io_buffer_full (io_buffer_full)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h13;
            32'h1001: return 8'h05;
            32'h1002: return 8'h00;
            32'h1003: return 8'h00;
            32'h2002: return 8'hEF;
            32'h2003: return 8'hBE;
            default:  return (a[31:8] == 24'h000030) ? 8'h00 : (a[7:0] ^ a[15:8] ^ 8'h3C);
        endcase
    endfunction

    function automatic logic [7:0] dev_rd(input logic [31:0] a);
        return dev_ram.exists(a) ? dev_ram[a] : init_byte(a);
    endfunction

    // RAM: address seen this cycle is read back next cycle; writes land at the cycle end.
    always @(negedge clk) begin
        if (mem_wr) begin
            dev_ram[mem_a] = mem_dout;
            wr_total = wr_total + 1;
        end
        if (ic_val_sgn) ic_pulses = ic_pulses + 1;
        mem_din = dev_rd(mem_a);
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] model_byte(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] v = '0;
        for (int k = 0; k < nbytes(sz); k++)
            v = v | (32'(model_byte(a + 32'(k))) << (8 * k));
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int k = 0; k < nbytes(sz); k++)
            exp_mem[a + 32'(k)] = 8'((wd >> (8 * k)) & 32'hFF);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_ls(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int cyc, output int nw);
        int w0;
        w0 = wr_total;
        ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
        cyc = 0;
        do begin tick(); cyc++; end while (!ls_done && cyc < TO);
        ls_req = 1'b0;
        rd = ls_rdata;
        nw = wr_total - w0;
        chk("ls_done_seen", {31'd0, ls_done}, 32'd1);
        tick();
        chk("ls_done_one_cycle", {31'd0, ls_done}, 32'd0);
        if (wr) model_store(a, sz, wd);
    endtask

    task automatic run_ic(input logic [31:0] a, output logic [31:0] v, output int cyc);
        ic_addr = a; ic_addr_sgn = 1'b1;
        cyc = 0;
        do begin tick(); cyc++; end while (!ic_val_sgn && cyc < TO);
        ic_addr_sgn = 1'b0;
        v = ic_val;
        chk("ic_done_seen", {31'd0, ic_val_sgn}, 32'd1);
        tick();
        chk("ic_done_one_cycle", {31'd0, ic_val_sgn}, 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          cyc;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_v;
        logic [31:0] ra;
        logic [1:0]  rsz;
        logic [31:0] rwd;
        int          cyc;
        int          nw;
        int          w0;
        int          p0;
        int          kind;

        tbl[0]  = '{1'b1, 2'd2, 32'h3000,     32'hDEADBEEF, 32'h0,        5};
        tbl[1]  = '{1'b0, 2'd2, 32'h3000,     32'h0,        32'hDEADBEEF, 5};
        tbl[2]  = '{1'b0, 2'd1, 32'h3002,     32'h0,        32'h0000DEAD, 3};
        tbl[3]  = '{1'b0, 2'd0, 32'h3001,     32'h0,        32'h000000BE, 2};
        tbl[4]  = '{1'b1, 2'd0, 32'h3001,     32'h1122335A, 32'h0,        2};
        tbl[5]  = '{1'b0, 2'd2, 32'h3000,     32'h0,        32'hDEAD5AEF, 5};
        tbl[6]  = '{1'b1, 2'd1, 32'h3003,     32'hFFFF1234, 32'h0,        3};
        tbl[7]  = '{1'b0, 2'd2, 32'h3002,     32'h0,        32'h001234AD, 5};
        tbl[8]  = '{1'b0, 2'd3, 32'h3000,     32'h0,        32'h34AD5AEF, 5};
        tbl[9]  = '{1'b0, 2'd0, 32'h3004,     32'h0,        32'h00000012, 2};
        tbl[10] = '{1'b1, 2'd3, 32'h30FE,     32'hA1B2C3D4, 32'h0,        5};
        tbl[11] = '{1'b0, 2'd2, 32'h30FF,     32'h0,        32'h0FA1B2C3, 5};
        tbl[12] = '{1'b1, 2'd2, 32'hFFFFFFFE, 32'h55667788, 32'h0,        5};
        tbl[13] = '{1'b0, 2'd2, 32'hFFFFFFFE, 32'h0,        32'h55667788, 5};

        // Reset state
        tick(); tick();
        chk("rst_ic_val", ic_val, 32'h0);
        chk("rst_ic_val_sgn", {31'd0, ic_val_sgn}, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        chk("rst_ls_done", {31'd0, ls_done}, 32'h0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
        rst = 1'b0;
        tick();

        // Icache fetch with address sequence
        ic_addr = 32'h1000; ic_addr_sgn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ifetch_mem_a", mem_a, 32'h1000 + 32'(k));
            chk("ifetch_early_sgn", {31'd0, ic_val_sgn}, 32'h0);
        end
        tick();
        chk("ifetch_sgn", {31'd0, ic_val_sgn}, 32'h1);
        chk("ifetch_val", ic_val, 32'h00000513);
        ic_addr_sgn = 1'b0;
        tick();
        chk("ifetch_sgn_one_cycle", {31'd0, ic_val_sgn}, 32'h0);
        chk("ifetch_val_hold", ic_val, 32'h00000513);

        // Load beats a simultaneous fetch; fetch follows
        ic_addr = 32'h1000; ic_addr_sgn = 1'b1;
        ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h2002; ls_req = 1'b1;
        cyc = 0;
        do begin tick(); cyc++; end while (!ls_done && cyc < TO);
        ls_req = 1'b0;
        chk("prio_load_cycles", 32'(cyc), 32'd3);
        chk("prio_load_data", ls_rdata, 32'h0000BEEF);
        chk("prio_no_fetch_yet", {31'd0, ic_val_sgn}, 32'h0);
        cyc = 0;
        do begin tick(); cyc++; end while (!ic_val_sgn && cyc < TO);
        ic_addr_sgn = 1'b0;
        chk("prio_fetch_cycles", 32'(cyc), 32'd6);
        chk("prio_fetch_data", ic_val, 32'h00000513);
        tick();

        // Table-driven LSB vectors
        for (int i = 0; i < 14; i++) begin
            run_ls(tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].wd, rd, cyc, nw);
            chk("tbl_cycles", 32'(cyc), 32'(tbl[i].cyc));
            chk("tbl_writes", 32'(nw), tbl[i].wr ? 32'(nbytes(tbl[i].sz)) : 32'd0);
            if (!tbl[i].wr) chk("tbl_rdata", rd, tbl[i].rd);
        end

        // Rollback after two fetch bytes
        w0 = wr_total; p0 = ic_pulses;
        ic_addr = 32'h1000; ic_addr_sgn = 1'b1;
        tick(); tick(); tick();
        rollback = 1'b1; ic_addr_sgn = 1'b0;
        tick();
        rollback = 1'b0;
        run_ls(1'b0, 2'd0, 32'h2003, 32'h0, rd, cyc, nw);
        chk("rb_fetch_new_req_cycles", 32'(cyc), 32'd2);
        chk("rb_fetch_new_req_data", rd, 32'h000000BE);
        chk("rb_fetch_no_pulse", 32'(ic_pulses - p0), 32'd0);
        chk("rb_fetch_no_write", 32'(wr_total - w0), 32'd0);
        chk("rb_fetch_val_hold", ic_val, 32'h00000513);

        // Rollback during a store
        w0 = wr_total;
        ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h3200; ls_wdata = 32'hCAFEF00D; ls_req = 1'b1;
        cyc = 0;
        tick(); cyc++;
        tick(); cyc++;
        rollback = 1'b1;
        tick(); cyc++;
        rollback = 1'b0;
        while (!ls_done && cyc < TO) begin tick(); cyc++; end
        ls_req = 1'b0;
        chk("rb_store_cycles", 32'(cyc), 32'd5);
        chk("rb_store_writes", 32'(wr_total - w0), 32'd4);
        model_store(32'h3200, 2'd2, 32'hCAFEF00D);
        tick();
        run_ls(1'b0, 2'd2, 32'h3200, 32'h0, rd, cyc, nw);
        chk("rb_store_readback", rd, 32'hCAFEF00D);

        // rdy low for three cycles mid-load
        exp_v = model_read(32'h3000, 2'd2);
        ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h3000; ls_req = 1'b1;
        cyc = 0;
        tick(); cyc++;
        tick(); cyc++;
        chk("rdy_mem_a_before", mem_a, 32'h3001);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); cyc++;
            chk("rdy_mem_a_frozen", mem_a, 32'h3001);
        end
        rdy = 1'b1;
        while (!ls_done && cyc < TO) begin tick(); cyc++; end
        ls_req = 1'b0;
        chk("rdy_cycles", 32'(cyc), 32'd8);
        chk("rdy_data", ls_rdata, exp_v);
        tick();

        // Asynchronous reset between edges during a load
        ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h3000; ls_req = 1'b1;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_a", mem_a, 32'h0);
        chk("arst_ls_rdata", ls_rdata, 32'h0);
        chk("arst_ic_val", ic_val, 32'h0);
        chk("arst_done", {30'd0, ls_done, ic_val_sgn}, 32'h0);
        chk("arst_mem_wr_dout", {23'd0, mem_wr, mem_dout}, 32'h0);
        @(negedge clk);
        rst = 1'b0; ls_req = 1'b0;
        tick();

        // Random traffic against the byte-level model
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 2));
            ra   = 32'h5000 + 32'($urandom_range(0, 63));
            rsz  = 2'($urandom_range(0, 3));
            rwd  = $urandom;
            if (kind == 2) begin
                ra = ra & 32'hFFFF_FFFC;
                exp_v = model_read(ra, 2'd2);
                run_ic(ra, rd, cyc);
                chk("rand_ic_data", rd, exp_v);
                chk("rand_ic_cycles", 32'(cyc), 32'd5);
            end else begin
                exp_v = model_read(ra, rsz);
                run_ls(kind == 0, rsz, ra, rwd, rd, cyc, nw);
                chk("rand_ls_cycles", 32'(cyc), 32'(nbytes(rsz) + 1));
                chk("rand_ls_writes", 32'(nw), (kind == 0) ? 32'(nbytes(rsz)) : 32'd0);
                if (kind == 1) chk("rand_ls_data", rd, exp_v);
            end
        end

        foreach (exp_mem[k]) chk("ram_byte", {24'd0, dev_rd(k)}, {24'd0, exp_mem[k]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
